// File: rtl/reduction_feeder.sv
// reduction_feeder
//   Front-end sequencer for the reduction tile accumulator. A job of
//   job_len_i tile rows arrives over a valid/ready stream. The block loads
//   the accumulator with a bias vector, packs rows into groups of PAR
//   operand vectors, and issues each group for exactly one cycle. After the
//   last group it captures the accumulated tile.
//
// Ports
//   CLK_i, RST_i        clock, synchronous active-high reset
//   job_start_i         start request, honoured only in IDLE
//   job_len_i           row count, latched on start
//   bias_i              initial accumulator tile, latched on start
//   job_busy_o          high whenever the FSM is not IDLE
//   row_valid_i/row_i   input row stream
//   row_ready_o         high in GATHER only
//   set_reg_o           registered bias, reset value of the reduction stage
//   acc_load_o          one-cycle accumulator load (reduction stage reset)
//   operand_o           PAR packed rows, slot k at bits [k*TILE_SIZE*WIDTH +: ...]
//   operand_valid_o     high in ISSUE
//   reduction_i         accumulator output of the reduction stage
//   result_o            captured accumulator tile, held until the next capture
//   result_valid_o      one-cycle pulse while result_o shows a new result
//   dbg_state_o         current FSM state, for monitors and assertions
//
// Handshake: a row transfers on a rising clock edge where row_valid_i and
// row_ready_o are both high. row_ready_o depends only on the state register,
// never on row_valid_i, and a producer may hold row_valid_i low for any
// number of cycles.
module reduction_feeder #(
  parameter int TILE_SIZE = 129,
  parameter int PAR       = 3,
  parameter int WIDTH     = 16,
  parameter int CNT_W     = 16
) (
  input  logic                           CLK_i,
  input  logic                           RST_i,
  input  logic                           job_start_i,
  input  logic [CNT_W-1:0]               job_len_i,
  input  logic [TILE_SIZE*WIDTH-1:0]     bias_i,
  output logic                           job_busy_o,
  input  logic                           row_valid_i,
  input  logic [TILE_SIZE*WIDTH-1:0]     row_i,
  output logic                           row_ready_o,
  output logic [TILE_SIZE*WIDTH-1:0]     set_reg_o,
  output logic                           acc_load_o,
  output logic [PAR*TILE_SIZE*WIDTH-1:0] operand_o,
  output logic                           operand_valid_o,
  input  logic [TILE_SIZE*WIDTH-1:0]     reduction_i,
  output logic [TILE_SIZE*WIDTH-1:0]     result_o,
  output logic                           result_valid_o,
  output logic [2:0]                     dbg_state_o
);

  localparam int TW     = TILE_SIZE * WIDTH;
  localparam int SLOT_W = $clog2(PAR + 1);

  localparam logic [SLOT_W-1:0] SLOT_FULL = SLOT_W'(PAR);
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_GATHER = 3'd2,
    S_ISSUE  = 3'd3,
    S_WAIT   = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        remaining_q, remaining_d;
  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic [PAR-1:0][TW-1:0]  stage_q, stage_d;
  logic [TW-1:0]           set_reg_q, set_reg_d;
  logic [TW-1:0]           result_q, result_d;

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      slot_q      <= '0;
      stage_q     <= '0;
      set_reg_q   <= '0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      slot_q      <= slot_d;
      stage_q     <= stage_d;
      set_reg_q   <= set_reg_d;
      result_q    <= result_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    slot_d      = slot_q;
    stage_d     = stage_q;
    set_reg_d   = set_reg_q;
    result_d    = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (job_start_i) begin
          remaining_d = job_len_i;
          set_reg_d   = bias_i;
          stage_d     = '0;
          slot_d      = '0;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = (remaining_q == '0) ? S_WAIT : S_GATHER;
      end
      S_GATHER: begin
        if (row_valid_i) begin
          stage_d[slot_q] = row_i;
          slot_d          = slot_q + SLOT_ONE;
          remaining_d     = remaining_q - CNT_ONE;
          // Issue as soon as the group is full or the job has no rows left;
          // a short final group keeps its unfilled slots at +0.
          if ((slot_d == SLOT_FULL) || (remaining_d == '0)) begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        stage_d = '0;
        slot_d  = '0;
        state_d = (remaining_q == '0) ? S_WAIT : S_GATHER;
      end
      S_WAIT: begin
        // The accumulator has absorbed the last group by now. Capturing on
        // the way into DONE makes result_o already hold the new tile during
        // the cycle result_valid_o is high.
        result_d = reduction_i;
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign job_busy_o      = (state_q != S_IDLE);
  assign row_ready_o     = (state_q == S_GATHER);
  assign acc_load_o      = (state_q == S_LOAD);
  assign operand_valid_o = (state_q == S_ISSUE);
  assign result_valid_o  = (state_q == S_DONE);
  // Zero operands outside ISSUE leave the always-accumulating stage unchanged.
  assign operand_o       = (state_q == S_ISSUE) ? stage_q : '0;
  assign set_reg_o       = set_reg_q;
  assign result_o        = result_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_reduction_feeder.sv
module tb_reduction_feeder;

  localparam int TS = 129;
  localparam int P  = 3;
  localparam int W  = 16;
  localparam int CW = 16;
  localparam int TW = TS * W;
  localparam int OW = P * TW;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          job_start_i;
  logic [CW-1:0] job_len_i;
  logic [TW-1:0] bias_i;
  logic          job_busy_o;
  logic          row_valid_i;
  logic [TW-1:0] row_i;
  logic          row_ready_o;
  logic [TW-1:0] set_reg_o;
  logic          acc_load_o;
  logic [OW-1:0] operand_o;
  logic          operand_valid_o;
  logic [TW-1:0] reduction_i;
  logic [TW-1:0] result_o;
  logic          result_valid_o;
  logic [2:0]    dbg_state_o;

  always #5 clk = ~clk;

  reduction_feeder #(.TILE_SIZE(TS), .PAR(P), .WIDTH(W), .CNT_W(CW)) dut (
    .CLK_i(clk), .RST_i(rst),
    .job_start_i(job_start_i), .job_len_i(job_len_i), .bias_i(bias_i),
    .job_busy_o(job_busy_o),
    .row_valid_i(row_valid_i), .row_i(row_i), .row_ready_o(row_ready_o),
    .set_reg_o(set_reg_o), .acc_load_o(acc_load_o),
    .operand_o(operand_o), .operand_valid_o(operand_valid_o),
    .reduction_i(reduction_i),
    .result_o(result_o), .result_valid_o(result_valid_o),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- fp16 helpers (non-negative integers only) ----------------
  function automatic logic [15:0] enc(input int n);
    int e;
    if (n == 0) return 16'h0000;
    e = 0;
    while ((n >> (e + 1)) != 0) e++;
    return {1'b0, 5'(e + 15), 10'((n << (10 - e)) & 'h3FF)};
  endfunction

  function automatic int dec(input logic [15:0] x);
    int e, m;
    if (x == 16'h0000) return 0;
    e = int'(x[14:10]) - 15;
    m = 1024 + int'(x[9:0]);
    return m >> (10 - e);
  endfunction

  function automatic logic [TW-1:0] fill(input int v);
    logic [TW-1:0] r;
    for (int l = 0; l < TS; l++) r[l*W +: W] = enc(v);
    return r;
  endfunction

  function automatic logic [TW-1:0] rand_vec();
    logic [TW-1:0] r;
    for (int l = 0; l < TS; l++) r[l*W +: W] = enc(int'($urandom_range(0, 7)));
    return r;
  endfunction

  // ---------------- behavioural reduction stage ----------------
  int acc [TS];
  always @(posedge clk) begin
    for (int l = 0; l < TS; l++) begin
      if (acc_load_o) acc[l] = dec(set_reg_o[l*W +: W]);
      else for (int k = 0; k < P; k++) acc[l] += dec(operand_o[k*TW + l*W +: W]);
      reduction_i[l*W +: W] <= enc(acc[l]);
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [OW-1:0] exp_q[$];
  logic [TW-1:0] rows_q[$];
  logic [TW-1:0] job_bias;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reports the first differing lane, keeping the line short.
  task automatic check_vec(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    int  lane;
    bit  found;
    lane  = 0;
    found = 1'b0;
    for (int i = 0; i < OW / W; i++) begin
      if (!found && (got[i*W +: W] !== exp[i*W +: W])) begin
        lane  = i;
        found = 1'b1;
      end
    end
    check($sformatf("%s[lane %0d]", tag, lane), 32'(got[lane*W +: W]), 32'(exp[lane*W +: W]));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, 32'(job_busy_o), 0);
    check({tag, "_ready"}, 32'(row_ready_o), 0);
    check({tag, "_load"}, 32'(acc_load_o), 0);
    check({tag, "_opvalid"}, 32'(operand_valid_o), 0);
    check({tag, "_resvalid"}, 32'(result_valid_o), 0);
    check_vec({tag, "_operand"}, operand_o, '0);
    check_vec({tag, "_setreg"}, OW'(set_reg_o), '0);
    check_vec({tag, "_result"}, OW'(result_o), '0);
  endtask

  // ---------------- driver: one complete job ----------------
  // Called at a negedge with the DUT in IDLE; rows_q and job_bias hold the job.
  task automatic run_job(input int len, input bit gaps, input bit stray_start);
    logic [OW-1:0] grp;
    logic [OW-1:0] exp_res;
    int n_groups, accepted, cyc, issues, pulses, last_issue, s;
    bit done;

    exp_q.delete();
    n_groups = (len + P - 1) / P;
    for (int g = 0; g < n_groups; g++) begin
      grp = '0;
      for (int k = 0; k < P; k++)
        if (g * P + k < len) grp[k*TW +: TW] = rows_q[g*P + k];
      exp_q.push_back(grp);
    end
    exp_res = '0;
    for (int l = 0; l < TS; l++) begin
      s = dec(job_bias[l*W +: W]);
      for (int r = 0; r < len; r++) s += dec(rows_q[r][l*W +: W]);
      exp_res[l*W +: W] = enc(s);
    end

    job_start_i = 1'b1;
    job_len_i   = CW'(len);
    bias_i      = job_bias;
    @(negedge clk);
    job_start_i = 1'b0;
    job_len_i   = CW'($urandom_range(0, 50));
    bias_i      = rand_vec();

    accepted = 0; cyc = 1; issues = 0; pulses = 0; last_issue = 0; done = 1'b0;
    while (!done && cyc < 500) begin
      check("acc_load", 32'(acc_load_o), 32'(cyc == 1));
      if (operand_valid_o) begin
        issues++;
        last_issue = cyc;
        if (exp_q.size() == 0) check("extra_issue", 1, 0);
        else check_vec("operand", operand_o, exp_q.pop_front());
      end else begin
        check_vec("operand_idle", operand_o, '0);
      end
      if (result_valid_o) begin
        pulses++;
        check_vec("result", OW'(result_o), exp_res);
        check("result_cycle", cyc, (len == 0) ? 3 : last_issue + 2);
      end else if (pulses > 0) begin
        check("busy_after_done", 32'(job_busy_o), 0);
        check_vec("result_hold", OW'(result_o), exp_res);
        done = 1'b1;
      end else begin
        check("busy", 32'(job_busy_o), 1);
      end

      job_start_i = stray_start && (cyc == 3);
      if (stray_start && cyc == 3) begin
        job_len_i = CW'(7);
        bias_i    = rand_vec();
      end
      if (accepted < len) begin
        row_valid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        row_i       = rows_q[accepted];
      end else begin
        row_valid_i = 1'($urandom_range(0, 1));
        row_i       = rand_vec();
      end
      if (row_ready_o && row_valid_i) accepted++;
      @(negedge clk);
      cyc++;
    end
    job_start_i = 1'b0;
    row_valid_i = 1'b0;
    if (!done) check("job_timeout", 0, 1);
    check("rows_accepted", accepted, len);
    check("issue_count", issues, n_groups);
    check("result_pulses", pulses, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int accepted, len;
    rst = 1'b1; job_start_i = 1'b0; job_len_i = '0; bias_i = '0;
    row_valid_i = 1'b0; row_i = '0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;
    @(negedge clk);

    // 1+2+3 on a zero bias -> 6.0
    job_bias = '0;
    rows_q = '{fill(1), fill(2), fill(3)};
    run_job(3, 1'b0, 1'b0);

    // five ones on a bias of one -> full group then a group with slot 2 empty
    job_bias = fill(1);
    rows_q = '{fill(1), fill(1), fill(1), fill(1), fill(1)};
    run_job(5, 1'b0, 1'b0);

    // empty job returns the bias
    job_bias = fill(5);
    rows_q.delete();
    run_job(0, 1'b0, 1'b0);

    // len=4 gap-free, then the same rows with random gaps and a stray start
    job_bias = rand_vec();
    rows_q.delete();
    for (int r = 0; r < 4; r++) rows_q.push_back(rand_vec());
    run_job(4, 1'b0, 1'b0);
    run_job(4, 1'b1, 1'b1);
    repeat (2) begin
      @(negedge clk);
      check("stray_start_ignored", 32'(job_busy_o), 0);
    end

    // reset after two rows of a len=6 job
    job_start_i = 1'b1; job_len_i = CW'(6); bias_i = fill(2);
    @(negedge clk);
    job_start_i = 1'b0;
    accepted = 0;
    for (int c = 0; c < 50 && accepted < 2; c++) begin
      row_valid_i = 1'b1;
      row_i       = fill(3);
      if (row_ready_o && row_valid_i) accepted++;
      @(negedge clk);
    end
    check("rows_before_reset", accepted, 2);
    row_valid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_quiet("midjob_reset");
    repeat (4) begin
      @(negedge clk);
      check("no_pulse_after_reset", 32'(result_valid_o), 0);
    end
    job_bias = fill(4);
    rows_q = '{fill(3)};
    run_job(1, 1'b0, 1'b0);

    // randomized jobs
    for (int j = 0; j < 12; j++) begin
      len = int'($urandom_range(0, 9));
      job_bias = rand_vec();
      rows_q.delete();
      for (int r = 0; r < len; r++) rows_q.push_back(rand_vec());
      run_job(len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
